// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, widths
// and the owner-selection rule used when leaving IDLE.
package bus_arb_pkg;

    // Owner states are one-hot so the state register doubles as the grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam int TMO_W  = 10;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    function automatic arb_state_e pick_owner(
        input logic stb0,
        input logic stb1,
        input logic last_m1,
        input logic fix_prio
    );
        arb_state_e nxt;
        nxt = ST_IDLE;
        if (stb0 && stb1) begin
            nxt = (fix_prio || last_m1) ? ST_OWN0 : ST_OWN1;
        end else if (stb0) begin
            nxt = ST_OWN0;
        end else if (stb1) begin
            nxt = ST_OWN1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bus_arb_tmo.sv
// Slave-ack watchdog: counts cycles of an ownership and flags when the
// count reaches the programmed limit.
module bus_arb_tmo
    import bus_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/bus_arb2.sv
// Two-master to one-slave bus arbiter with round-robin or fixed priority,
// combinational request/response muxing and a slave-ack timeout.
module bus_arb2
    import bus_arb_pkg::*;
#(
    parameter int TMO_CYCLES = 255,
    parameter bit FIX_PRIO   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic [DATA_W-1:0] m0_din,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic [DATA_W-1:0] m1_din,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_dout,
    input  logic [DATA_W-1:0] s_din,
    input  logic              s_ack,
    output logic [1:0]        grant
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYCLES - 1);

    arb_state_e state;
    logic       last_m1;
    logic       armed;
    logic       own0;
    logic       own1;
    logic       own_stb;
    logic       expired;
    logic       tmo_hit;
    logic       done_ok;

    assign own0    = (state == ST_OWN0);
    assign own1    = (state == ST_OWN1);
    assign own_stb = (own0 & m0_stb) | (own1 & m1_stb);

    // s_ack beats a same-cycle timeout; a dropped strobe ends the grant silently.
    assign done_ok = own_stb & s_ack;
    assign tmo_hit = own_stb & ~s_ack & expired;

    bus_arb_tmo u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .enable  (own_stb & ~s_ack),
        .limit   (TMO_LIMIT),
        .expired (expired)
    );

    // armed holds off the first grant until the second edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            last_m1 <= 1'b1;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed) begin
                        state <= pick_owner(m0_stb, m1_stb, last_m1, FIX_PRIO);
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (!own_stb) begin
                        state <= ST_IDLE;
                    end else if (s_ack || expired) begin
                        state   <= ST_IDLE;
                        last_m1 <= own1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign grant = state;

    always_comb begin
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_addr = '0;
        s_dout = '0;
        m0_din = '0;
        m0_ack = 1'b0;
        m0_err = 1'b0;
        m1_din = '0;
        m1_ack = 1'b0;
        m1_err = 1'b0;
        if (own0) begin
            s_stb  = m0_stb & ~tmo_hit;
            s_we   = m0_we;
            s_addr = m0_addr;
            s_dout = m0_dout;
            m0_din = s_din;
            m0_ack = done_ok | tmo_hit;
            m0_err = tmo_hit;
        end else if (own1) begin
            s_stb  = m1_stb & ~tmo_hit;
            s_we   = m1_we;
            s_addr = m1_addr;
            s_dout = m1_dout;
            m1_din = s_din;
            m1_ack = done_ok | tmo_hit;
            m1_err = tmo_hit;
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Randomized scoreboard bench for bus_arb2: a round-robin instance with an
// 8-cycle timeout, plus a fixed-priority instance for the m0-always-wins case.
module tb_bus_arb2;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        m0_stb, m0_we, m0_ack, m0_err;
    logic [21:0] m0_addr;
    logic [31:0] m0_dout, m0_din;
    logic        m1_stb, m1_we, m1_ack, m1_err;
    logic [21:0] m1_addr;
    logic [31:0] m1_dout, m1_din;
    logic        s_stb, s_we, s_ack;
    logic [21:0] s_addr;
    logic [31:0] s_dout, s_din;
    logic [1:0]  grant;

    logic        f_m0_stb, f_m0_we, f_m0_ack, f_m0_err;
    logic [21:0] f_m0_addr;
    logic [31:0] f_m0_dout, f_m0_din;
    logic        f_m1_stb, f_m1_we, f_m1_ack, f_m1_err;
    logic [21:0] f_m1_addr;
    logic [31:0] f_m1_dout, f_m1_din;
    logic        f_s_stb, f_s_we, f_s_ack;
    logic [21:0] f_s_addr;
    logic [31:0] f_s_dout, f_s_din;
    logic [1:0]  f_grant;

    bus_arb2 #(.TMO_CYCLES(TMO), .FIX_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_din(m0_din), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_din(m1_din), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dout(s_dout),
        .s_din(s_din), .s_ack(s_ack), .grant(grant)
    );

    bus_arb2 #(.FIX_PRIO(1'b1)) u_fix (
        .clk(clk), .rst(rst),
        .m0_stb(f_m0_stb), .m0_we(f_m0_we), .m0_addr(f_m0_addr), .m0_dout(f_m0_dout),
        .m0_din(f_m0_din), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
        .m1_stb(f_m1_stb), .m1_we(f_m1_we), .m1_addr(f_m1_addr), .m1_dout(f_m1_dout),
        .m1_din(f_m1_din), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
        .s_stb(f_s_stb), .s_we(f_s_we), .s_addr(f_s_addr), .s_dout(f_s_dout),
        .s_din(f_s_din), .s_ack(f_s_ack), .grant(f_grant)
    );

    typedef struct {
        bit          mst;
        bit          we;
        logic [21:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        bit          mst;
        bit          err;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    last_m = 1'b1;
    bit    mon_en = 1'b0;
    bit    skip_gap = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Slave: each grant consumes one plan; acks in cycle index dly of the grant.
    initial begin : slave
        bit    act;
        int    cnt;
        plan_t p;
        act = 1'b0; cnt = 0; p.dly = -1;
        s_ack = 1'b0; s_din = '0;
        forever begin
            @(negedge clk);
            s_din = $urandom;
            s_ack = 1'b0;
            if (grant != 2'b00) begin
                if (!act) begin
                    act = 1'b1;
                    cnt = 0;
                    if (plan_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL slave_plan: grant %0b with nothing pending", grant);
                        p.dly = -1;
                    end else begin
                        p = plan_q.pop_front();
                        chk("slave_grant", grant, p.mst ? 2'b10 : 2'b01);
                        chk("slave_stb", s_stb, 1);
                        chk("slave_we", s_we, p.we);
                        chk("slave_addr", s_addr, p.addr);
                        if (p.we) chk("slave_wdata", s_dout, p.wdata);
                    end
                end
                if (cnt == p.dly) begin
                    s_ack = 1'b1;
                    s_din = p.rdata;
                end
                cnt++;
            end else begin
                act = 1'b0;
                s_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : fix_slave
        f_s_ack = 1'b0;
        f_s_din = 32'hC0FFEE00;
        forever begin
            @(negedge clk);
            f_s_ack = f_s_stb;
        end
    end

    initial begin : monitor
        int   gcyc;
        int   idle_req;
        exp_t e;
        gcyc = 0; idle_req = 0;
        forever begin
            @(negedge clk); #2;
            if (mon_en) begin
                chk("grant_legal", grant == 2'b11, 0);
                if (grant == 2'b00) begin
                    chk("idle_bus", {s_stb, s_we, s_addr, s_dout}, 0);
                    chk("idle_ack", {m0_ack, m0_err, m1_ack, m1_err}, 0);
                    gcyc = 0;
                    idle_req = (m0_stb | m1_stb) ? idle_req + 1 : 0;
                end else begin
                    if (gcyc == 0) begin
                        if (!skip_gap) chk("arb_gap", idle_req, 1);
                        skip_gap = 1'b0;
                    end
                    gcyc++;
                    idle_req = 0;
                end
                chk("din_gate", (!grant[0] && m0_din != 0) || (!grant[1] && m1_din != 0), 0);
                chk("err_wo_ack", (m0_err && !m0_ack) || (m1_err && !m1_ack), 0);
                chk("ack_owner", (m0_ack && !grant[0]) || (m1_ack && !grant[1]), 0);
                if (m0_ack || m1_ack) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL ack_unexpected: m0_ack=%0b m1_ack=%0b", m0_ack, m1_ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_master", m1_ack, e.mst);
                        chk("ack_err", m0_err | m1_err, e.err);
                        if (!e.err) chk("ack_din", e.mst ? m1_din : m0_din, e.rdata);
                        chk("ack_latency", gcyc, e.cycles);
                        chk("ack_s_stb", s_stb, !e.err);
                    end
                end
            end
        end
    end

    task automatic idle_m0();
        m0_stb = 1'b0; m0_we = 1'($urandom); m0_addr = 22'($urandom); m0_dout = $urandom;
    endtask

    task automatic idle_m1();
        m1_stb = 1'b0; m1_we = 1'($urandom); m1_addr = 22'($urandom); m1_dout = $urandom;
    endtask

    // One round: the selected masters request together and hold until acked.
    // Called and returns at posedge+1.
    task automatic run_round(input int sel, input int dly0, input int dly1, input bit fixed_read);
        plan_t p[2];
        exp_t  e;
        bit    first, m, done0, done1;
        int    n;
        for (int i = 0; i < 2; i++) begin
            p[i].mst   = (i == 1);
            p[i].we    = 1'($urandom);
            p[i].addr  = 22'($urandom);
            p[i].wdata = $urandom;
            p[i].rdata = $urandom;
            p[i].dly   = $urandom_range(0, TMO + 2);
        end
        if (dly0 >= 0) p[0].dly = dly0;
        if (dly1 >= 0) p[1].dly = dly1;
        if (fixed_read) begin
            p[0].we = 1'b0; p[0].addr = 22'h00100; p[0].rdata = 32'hDEADBEEF;
        end
        // Tie goes to whoever was not served last; otherwise the lone requester.
        first = (sel == 3) ? !last_m : (sel == 2);
        for (int k = 0; k < 2; k++) begin
            m = first ^ (k == 1);
            if (sel[m]) begin
                plan_q.push_back(p[m]);
                e.mst    = m;
                e.err    = (p[m].dly > TMO - 1);
                e.rdata  = p[m].rdata;
                e.cycles = e.err ? TMO : p[m].dly + 1;
                exp_q.push_back(e);
                last_m = m;
            end
        end
        if (sel[0]) begin
            m0_we = p[0].we; m0_addr = p[0].addr; m0_dout = p[0].wdata; m0_stb = 1'b1;
        end
        if (sel[1]) begin
            m1_we = p[1].we; m1_addr = p[1].addr; m1_dout = p[1].wdata; m1_stb = 1'b1;
        end
        done0 = !sel[0];
        done1 = !sel[1];
        n = 0;
        while (!(done0 && done1) && n < 60) begin
            @(negedge clk); #2;
            if (m0_ack) done0 = 1'b1;
            if (m1_ack) done1 = 1'b1;
            @(posedge clk); #1;
            if (done0) idle_m0();
            if (done1) idle_m1();
            n++;
        end
        if (!(done0 && done1)) begin
            tests++; fails++;
            $display("FAIL round_timeout: sel=%0d done0=%0b done1=%0b", sel, done0, done1);
            idle_m0(); idle_m1();
        end
    endtask

    task automatic run_reset();
        plan_t p;
        exp_t  e;
        bit    done;
        int    n;
        repeat (2) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        p.mst = 1'b0; p.we = 1'b1; p.addr = 22'($urandom); p.wdata = $urandom;
        p.rdata = $urandom; p.dly = 1000;
        plan_q.push_back(p);
        m0_we = p.we; m0_addr = p.addr; m0_dout = p.wdata; m0_stb = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_grant", grant, 2'b01);
        @(negedge clk); #3;
        rst = 1'b0;
        #1;
        chk("rst_async_grant", grant, 0);
        chk("rst_async_sstb", s_stb, 0);
        chk("rst_async_ack", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        last_m = 1'b1;
        p.dly = $urandom_range(0, 3);
        plan_q.push_back(p);
        e.mst = 1'b0; e.err = 1'b0; e.rdata = p.rdata; e.cycles = p.dly + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("rst_first_edge_idle", grant, 0);
        @(posedge clk); #1;
        chk("rst_second_edge_grant", grant, 2'b01);
        skip_gap = 1'b1;
        mon_en = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk); #2;
            if (m0_ack) done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        idle_m0();
        if (!done) begin
            tests++; fails++;
            $display("FAIL rst_rerequest: no ack after reset release");
        end
    endtask

    // Fixed priority: both hold strobe continuously; m0 must take every grant.
    task automatic run_fix();
        int n0, n1;
        n0 = 0; n1 = 0;
        f_m0_stb = 1'b1; f_m1_stb = 1'b1;
        repeat (24) begin
            @(negedge clk); #2;
            if (f_m0_ack) begin
                n0++;
                chk("fix_m0_din", f_m0_din, 32'hC0FFEE00);
            end
            if (f_m1_ack) n1++;
            chk("fix_grant_m1", f_grant[1], 0);
        end
        @(posedge clk); #1;
        f_m0_stb = 1'b0; f_m1_stb = 1'b0;
        chk("fix_m0_count", n0, 12);
        chk("fix_m1_count", n1, 0);
    endtask

    initial begin : main
        idle_m0(); idle_m1();
        f_m0_stb = 1'b0; f_m0_we = 1'b0; f_m0_addr = 22'h1234; f_m0_dout = 32'h0;
        f_m1_stb = 1'b0; f_m1_we = 1'b1; f_m1_addr = 22'h3210; f_m1_dout = 32'h1;
        #2;
        chk("reset_grant", grant, 0);
        chk("reset_bus", {s_stb, s_we, s_addr, s_dout}, 0);
        chk("reset_ack", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mon_en = 1'b1;

        repeat (4) run_round(3, 1, 2, 1'b0);
        run_round(1, 3, -1, 1'b1);
        run_round(2, TMO + 5, -1, 1'b0);
        run_round(2, TMO - 1, -1, 1'b0);
        run_round(1, TMO, -1, 1'b0);
        repeat (150) begin
            run_round($urandom_range(1, 3), -1, -1, 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        run_reset();
        run_fix();

        repeat (3) begin @(posedge clk); #1; end
        chk("exp_drained", exp_q.size(), 0);
        chk("plan_drained", plan_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
